// File: rtl/float_unpack_acc.sv
// Undoes the 4-bit float normaliser: shifts F right P times (one bit per clock),
// emits the restored value and keeps a running sum, item count and sticky flags.
module float_unpack_acc #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_f,
  input  logic [1:0]       in_p,
  output logic             out_valid,
  output logic [3:0]       out_value,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_r;
  state_t         state_s;
  logic [3:0]     sh_r;
  logic [1:0]     n_r;
  logic [ACC_W:0] sum_ext_s;
  logic           bad_norm_s;

  assign sum_ext_s  = {1'b0, sum} + (ACC_W+1)'(sh_r);
  assign bad_norm_s = (in_f != 4'd0) && (in_f[3] == 1'b0);
  // Held low while in reset so the upstream never sees a ready during rst_n=0.
  assign in_ready   = rst_n && (state_r == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: accept in IDLE, return once the shift count is exhausted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (n_r == 2'd0) begin
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: shifter, result register, accumulator and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r      <= 4'd0;
      n_r       <= 2'd0;
      out_valid <= 1'b0;
      out_value <= 4'd0;
      sum       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sh_r <= in_f;
            n_r  <= in_p;
            if (bad_norm_s && !clr) begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (n_r != 2'd0) begin
            sh_r <= sh_r >> 1;
            n_r  <= n_r - 2'd1;
          end else begin
            out_value <= sh_r;
            out_valid <= 1'b1;
            sum       <= sum_ext_s[ACC_W-1:0];
            count     <= count + CNT_W'(1);
            if (sum_ext_s[ACC_W]) begin
              ovf <= 1'b1;
            end
          end
        end
        default: begin
          sh_r <= 4'd0;
          n_r  <= 2'd0;
        end
      endcase
      // Clear overrides any accumulation on the same edge; the result itself still emerges.
      if (clr) begin
        sum   <= '0;
        count <= '0;
        ovf   <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_float_unpack_acc.sv
// Self-checking bench for float_unpack_acc: directed scenarios plus a randomized
// run, all compared against an arithmetic reference model (U = F >> P).
module tb_float_unpack_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_f = 4'd0;
  logic [1:0] in_p = 2'd0;
  logic       out_valid;
  logic [3:0] out_value;
  logic [7:0] sum;
  logic [3:0] count;
  logic       ovf;
  logic       err;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_sum = 0;
  int m_count = 0;
  bit m_ovf = 1'b0;
  bit m_err = 1'b0;

  float_unpack_acc #(.ACC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_p(in_p), .out_valid(out_valid), .out_value(out_value),
    .sum(sum), .count(count), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_sum = 0; m_count = 0; m_ovf = 1'b0; m_err = 1'b0;
  endfunction

  task automatic check_totals(input string tag);
    checks++;
    if (sum !== m_sum[7:0]) begin
      failures++; $display("FAIL %s sum: got %0h expected %0h", tag, sum, m_sum[7:0]);
    end
    checks++;
    if (count !== m_count[3:0]) begin
      failures++; $display("FAIL %s count: got %0d expected %0d", tag, count, m_count[3:0]);
    end
    checks++;
    if (ovf !== m_ovf) begin
      failures++; $display("FAIL %s ovf: got %0b expected %0b", tag, ovf, m_ovf);
    end
    checks++;
    if (err !== m_err) begin
      failures++; $display("FAIL %s err: got %0b expected %0b", tag, err, m_err);
    end
  endtask

  // One full conversion, entered and left at a negedge. clr_res raises clr on the result edge.
  task automatic do_item(input logic [3:0] f, input logic [1:0] p, input bit clr_res,
                         input string tag);
    int u;
    int total;
    u = int'(f) >> p;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_at_start: got %0b expected 1", tag, in_ready);
    end
    in_f = f; in_p = p; in_valid = 1'b1;
    @(posedge clk);
    if (f != 4'd0 && f[3] == 1'b0) m_err = 1'b1;
    for (int i = 1; i <= int'(p) + 2; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1);   // ignored while busy
      in_f = 4'($urandom);
      in_p = 2'($urandom);
      clr = (clr_res && i == int'(p) + 1);
      if (i <= int'(p) + 1) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_cycle%0d: ready=%0b valid=%0b expected 0/0",
                   tag, i, in_ready, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    if (clr_res) begin
      model_reset();
    end else begin
      total = m_sum + u;
      if (total > 255) m_ovf = 1'b1;
      m_sum = total % 256;
      m_count = (m_count + 1) % 16;
    end
    checks++;
    if (out_valid !== 1'b1 || out_value !== 4'(u)) begin
      failures++;
      $display("FAIL %s result: valid=%0b value=%0d expected 1/%0d", tag, out_valid, out_value, u);
    end
    check_totals(tag);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_value !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b value=%0d expected 0/0/0",
               in_ready, out_valid, out_value);
    end
    model_reset();
    check_totals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    do_item(4'b1000, 2'd3, 1'b0, "single");
    checks++;
    if (sum !== 8'd1 || count !== 4'd1) begin
      failures++; $display("FAIL single_abs: sum=%0d count=%0d expected 1/1", sum, count);
    end
  endtask

  task automatic test_normaliser_set();
    logic [3:0] fs [6] = '{4'b1000, 4'b1000, 4'b1110, 4'b1010, 4'b1100, 4'b1111};
    logic [1:0] ps [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    pulse_clr();
    for (int i = 0; i < 6; i++) do_item(fs[i], ps[i], 1'b0, "normset");
    checks++;
    if (sum !== 8'h2F || count !== 4'd6 || ovf !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL normset_abs: sum=%0h count=%0d ovf=%0b err=%0b expected 2f/6/0/0",
               sum, count, ovf, err);
    end
  endtask

  task automatic test_overflow();
    pulse_clr();
    for (int i = 0; i < 18; i++) begin
      do_item(4'b1111, 2'd0, 1'b0, "ovf");
      if (i == 16) begin
        checks++;
        if (sum !== 8'hFF || ovf !== 1'b0) begin
          failures++; $display("FAIL ovf_17: sum=%0h ovf=%0b expected ff/0", sum, ovf);
        end
      end
    end
    checks++;
    if (sum !== 8'h0E || ovf !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL ovf_18: sum=%0h ovf=%0b count=%0d expected 0e/1/2", sum, ovf, count);
    end
  endtask

  task automatic test_err_clr();
    pulse_clr();
    do_item(4'b0110, 2'd0, 1'b0, "err_bad");
    do_item(4'b0000, 2'd2, 1'b0, "err_zero");
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_sticky: got %0b expected 1", err);
    end
    pulse_clr();
    check_totals("err_clr");
    checks++;
    if (sum !== 8'd0 || err !== 1'b0) begin
      failures++; $display("FAIL err_clr_abs: sum=%0d err=%0b expected 0/0", sum, err);
    end
  endtask

  task automatic test_clr_on_result();
    do_item(4'b1010, 2'd1, 1'b0, "pre_clr");
    do_item(4'b1100, 2'd1, 1'b1, "clr_result");
    checks++;
    if (out_value !== 4'd6 || sum !== 8'd0 || count !== 4'd0) begin
      failures++;
      $display("FAIL clr_result_abs: value=%0d sum=%0d count=%0d expected 6/0/0",
               out_value, sum, count);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    do_item(4'b1110, 2'd0, 1'b0, "pre_rst");
    in_f = 4'b1000; in_p = 2'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_value !== 4'd0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid: value=%0d ready=%0b expected 0/0", out_value, in_ready);
    end
    check_totals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_after: valid_seen=%0b ready=%0b expected 0/1", seen, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_clr();
      do_item(4'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  task automatic test_back_to_back();
    // do_item hands off on the result cycle, so these accepts are gap-free
    for (int i = 0; i < 8; i++) do_item(4'(8 + i), 2'(i), 1'b0, "b2b");
    check_totals("b2b_end");
  endtask

  initial begin
    test_reset();
    test_single();
    test_normaliser_set();
    test_overflow();
    test_err_clr();
    test_clr_on_result();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
